// File: rtl/debug_dump_pkg.sv
// Shared encodings for the debug dump sequencer: FSM states, dump phases and the
// header word layout used when DEBUG_DUMP_HEADER_EN is defined.
package debug_dump_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HDR     = 3'd1;
   localparam logic [2:0] ST_PC      = 3'd2;
   localparam logic [2:0] ST_ADDR    = 3'd3;
   localparam logic [2:0] ST_CAPT    = 3'd4;
   localparam logic [2:0] ST_SEND    = 3'd5;
   localparam logic [2:0] ST_WAIT_TX = 3'd6;
   localparam logic [2:0] ST_DONE    = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_HDR     = ST_HDR,
      S_PC      = ST_PC,
      S_ADDR    = ST_ADDR,
      S_CAPT    = ST_CAPT,
      S_SEND    = ST_SEND,
      S_WAIT_TX = ST_WAIT_TX,
      S_DONE    = ST_DONE
   } dump_state_e;

   // PH_HDR is only ever entered when the header word is enabled.
   localparam logic [1:0] PH_HDR = 2'd0;
   localparam logic [1:0] PH_PC  = 2'd1;
   localparam logic [1:0] PH_REG = 2'd2;
   localparam logic [1:0] PH_MEM = 2'd3;

   typedef enum logic [1:0] {
      P_HDR = PH_HDR,
      P_PC  = PH_PC,
      P_REG = PH_REG,
      P_MEM = PH_MEM
   } dump_phase_e;

   localparam logic [15:0] DUMP_HDR_MAGIC = 16'hD0D0;

   // Header word: magic in the top half, count of words that follow it in the bottom half.
   function automatic logic [31:0] dump_header(input int unsigned n_regs, input int unsigned n_mem);
      return {DUMP_HDR_MAGIC, 16'(1 + n_regs + n_mem)};
   endfunction

endpackage

// File: rtl/dump_index_counter.sv
// Word index within the current dump phase: clear, increment, and a terminal flag
// when the index equals the last valid address of the phase.
module dump_index_counter #(
   parameter int W = 7
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic         i_clear,
   input  logic         i_inc,
   input  logic [W-1:0] i_last,
   output logic [W-1:0] o_count,
   output logic         o_terminal
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign o_terminal = (count_q == i_last);
   assign o_count    = count_q;

   // Saturates at the terminal index so a stray increment never wraps.
   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = '0;
      end else if (i_inc && !o_terminal) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Walks PC, register file and data memory, sending each word through one uart_32b
// transmit. Define DEBUG_DUMP_HEADER_EN to prepend a magic/length header word.
module debug_dump_sequencer
   import debug_dump_pkg::*;
#(
   parameter int TAM_DATA      = 32,
   parameter int TAM_DIREC_REG = 5,
   parameter int TAM_DIREC_MEM = 7,
   parameter int NUM_REGS      = 32,
   parameter int NUM_MEM_WORDS = 128
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_start,
   input  logic                     i_abort,
   input  logic [TAM_DATA-1:0]      i_pc,
   input  logic [TAM_DATA-1:0]      i_reg_data,
   input  logic [TAM_DATA-1:0]      i_mem_data,
   input  logic                     i_tx_done_32b,
   output logic [TAM_DIREC_REG-1:0] o_reg_addr,
   output logic [TAM_DIREC_MEM-1:0] o_mem_addr,
   output logic [TAM_DATA-1:0]      o_tx_data,
   output logic                     o_tx_start_32b,
   output logic                     o_busy,
   output logic                     o_done
);

   localparam int CW = (TAM_DIREC_REG > TAM_DIREC_MEM) ? TAM_DIREC_REG : TAM_DIREC_MEM;

   dump_state_e              state_q,    state_d;
   dump_phase_e              phase_q,    phase_d;
   logic                     busy_q,     busy_d;
   logic                     done_q,     done_d;
   logic                     tx_start_q, tx_start_d;
   logic [TAM_DATA-1:0]      tx_data_q,  tx_data_d;
   logic [TAM_DIREC_REG-1:0] reg_addr_q, reg_addr_d;
   logic [TAM_DIREC_MEM-1:0] mem_addr_q, mem_addr_d;

   logic          cnt_clear;
   logic          cnt_inc;
   logic [CW-1:0] cnt_last;
   logic [CW-1:0] cnt_count;
   logic [CW-1:0] cnt_plus1;
   logic          cnt_terminal;

   assign cnt_last  = (phase_q == P_MEM) ? CW'(NUM_MEM_WORDS - 1) : CW'(NUM_REGS - 1);
   assign cnt_plus1 = cnt_count + CW'(1);

   dump_index_counter #(
      .W (CW)
   ) u_index (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_clear    (cnt_clear),
      .i_inc      (cnt_inc),
      .i_last     (cnt_last),
      .o_count    (cnt_count),
      .o_terminal (cnt_terminal)
   );

   // The address register is loaded on the way into ADDR, so the read port sees it
   // for the whole ADDR cycle and its data is ready to capture at the end of CAPT.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      reg_addr_d = reg_addr_q;
      mem_addr_d = mem_addr_q;
      cnt_clear  = 1'b0;
      cnt_inc    = 1'b0;

      if (state_q != S_IDLE && i_abort) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  busy_d    = 1'b1;
                  cnt_clear = 1'b1;
`ifdef DEBUG_DUMP_HEADER_EN
                  state_d   = S_HDR;
                  phase_d   = P_HDR;
`else
                  state_d   = S_PC;
                  phase_d   = P_PC;
`endif
               end
            end
`ifdef DEBUG_DUMP_HEADER_EN
            S_HDR: begin
               tx_data_d = TAM_DATA'(dump_header(NUM_REGS, NUM_MEM_WORDS));
               state_d   = S_SEND;
            end
`endif
            S_PC: begin
               tx_data_d = i_pc;
               state_d   = S_SEND;
            end
            S_ADDR: begin
               state_d = S_CAPT;
            end
            S_CAPT: begin
               tx_data_d = (phase_q == P_MEM) ? i_mem_data : i_reg_data;
               state_d   = S_SEND;
            end
            S_SEND: begin
               tx_start_d = 1'b1;
               state_d    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
               if (i_tx_done_32b) begin
                  case (phase_q)
                     P_HDR: begin
                        phase_d = P_PC;
                        state_d = S_PC;
                     end
                     P_PC: begin
                        phase_d    = P_REG;
                        cnt_clear  = 1'b1;
                        reg_addr_d = '0;
                        state_d    = S_ADDR;
                     end
                     P_REG: begin
                        if (cnt_terminal) begin
                           phase_d    = P_MEM;
                           cnt_clear  = 1'b1;
                           mem_addr_d = '0;
                        end else begin
                           cnt_inc    = 1'b1;
                           reg_addr_d = cnt_plus1[TAM_DIREC_REG-1:0];
                        end
                        state_d = S_ADDR;
                     end
                     default: begin
                        if (cnt_terminal) begin
                           state_d = S_DONE;
                        end else begin
                           cnt_inc    = 1'b1;
                           mem_addr_d = cnt_plus1[TAM_DIREC_MEM-1:0];
                           state_d    = S_ADDR;
                        end
                     end
                  endcase
               end
            end
            S_DONE: begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state_q    <= S_IDLE;
         phase_q    <= P_PC;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         reg_addr_q <= '0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         reg_addr_q <= reg_addr_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign o_reg_addr     = reg_addr_q;
   assign o_mem_addr     = mem_addr_q;
   assign o_tx_data      = tx_data_q;
   assign o_tx_start_32b = tx_start_q;
   assign o_busy         = busy_q;
   assign o_done         = done_q;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Bench for debug_dump_sequencer: a small instance (4 regs, 3 mem words) driven from a
// row table plus random rows, and a default-size instance for reset in the middle of a dump.
module tb_debug_dump_sequencer;

   localparam int SR = 4;
   localparam int SM = 3;
   localparam int BR = 32;
   localparam int BM = 128;
`ifdef DEBUG_DUMP_HEADER_EN
   localparam int H = 1;
`else
   localparam int H = 0;
`endif
   localparam int NW    = H + 1 + SR + SM;
   localparam int NROWS = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // small instance
   logic        rst_n, main_start, noise_start, start, abort;
   logic        uart_done, spur_done, tx_done;
   logic [31:0] pc, reg_data, mem_data, tx_data;
   logic [4:0]  reg_addr;
   logic [6:0]  mem_addr;
   logic        tx_start, busy, done;

   assign start   = main_start | noise_start;
   assign tx_done = uart_done | spur_done;

   debug_dump_sequencer #(
      .TAM_DATA (32), .TAM_DIREC_REG (5), .TAM_DIREC_MEM (7),
      .NUM_REGS (SR), .NUM_MEM_WORDS (SM)
   ) u_dut (
      .i_clock (clk), .i_reset (rst_n), .i_start (start), .i_abort (abort),
      .i_pc (pc), .i_reg_data (reg_data), .i_mem_data (mem_data),
      .i_tx_done_32b (tx_done), .o_reg_addr (reg_addr), .o_mem_addr (mem_addr),
      .o_tx_data (tx_data), .o_tx_start_32b (tx_start), .o_busy (busy), .o_done (done)
   );

   // default-size instance
   logic        b_rst_n, b_start, b_abort, b_done_in;
   logic [31:0] b_pc, b_reg_data, b_mem_data, b_tx_data;
   logic [4:0]  b_reg_addr;
   logic [6:0]  b_mem_addr;
   logic        b_tx_start, b_busy, b_done;

   debug_dump_sequencer u_big (
      .i_clock (clk), .i_reset (b_rst_n), .i_start (b_start), .i_abort (b_abort),
      .i_pc (b_pc), .i_reg_data (b_reg_data), .i_mem_data (b_mem_data),
      .i_tx_done_32b (b_done_in), .o_reg_addr (b_reg_addr), .o_mem_addr (b_mem_addr),
      .o_tx_data (b_tx_data), .o_tx_start_32b (b_tx_start), .o_busy (b_busy), .o_done (b_done)
   );

   // MIPS debug read ports: one-cycle registered read
   always @(posedge clk) begin
      reg_data   <= 32'h100 + 32'(reg_addr);
      mem_data   <= 32'h200 + 32'(mem_addr);
      b_reg_data <= 32'h100 + 32'(b_reg_addr);
      b_mem_data <= 32'h200 + 32'(b_mem_addr);
   end

   int tests = 0;
   int fails = 0;
   int uart_delay = 10;
   bit noise_on = 1'b0;
   bit uart_busy = 1'b0;

   // uart_32b model: done pulse uart_delay cycles after each strobe
   initial begin
      uart_done = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start) begin
            uart_busy = 1'b1;
            repeat (uart_delay) @(posedge clk);
            #1 uart_done = 1'b1;
            @(posedge clk);
            #1 uart_done = 1'b0;
            uart_busy = 1'b0;
         end
      end
   end

   // noise: start re-pulsed while a word is in flight
   initial begin
      int off;
      noise_start = 1'b0;
      forever begin
         @(negedge clk);
         if (noise_on && tx_start) begin
            off = int'($urandom_range(1, uart_delay));
            repeat (off) @(posedge clk);
            #1 noise_start = 1'b1;
            @(posedge clk);
            #1 noise_start = 1'b0;
         end
      end
   end

   // noise: tx-done stretched into the ADDR cycle that follows it
   initial begin
      spur_done = 1'b0;
      forever begin
         @(negedge clk);
         if (noise_on && uart_done) begin
            @(posedge clk);
            #1 spur_done = 1'b1;
            @(posedge clk);
            #1 spur_done = 1'b0;
         end
      end
   end

   // scoreboard capture: strobed words, done pulses, hold violations while a word is in flight
   logic [31:0] got[$];
   int          done_cnt = 0;
   int          stab_bad = 0;
   bit          pend = 1'b0;
   logic [31:0] held_data;
   logic [4:0]  held_ra;
   logic [6:0]  held_ma;

   always @(negedge clk) begin
      if (!rst_n) begin
         pend <= 1'b0;
      end else if (tx_start) begin
         got.push_back(tx_data);
         pend      <= 1'b1;
         held_data <= tx_data;
         held_ra   <= reg_addr;
         held_ma   <= mem_addr;
      end else if (pend) begin
         if (tx_data != held_data || reg_addr != held_ra || mem_addr != held_ma)
            stab_bad <= stab_bad + 1;
         if (tx_done)
            pend <= 1'b0;
      end
      if (done)
         done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Word k of a dump: optional header, PC, registers in order, memory words in order.
   function automatic logic [31:0] model_word(input int k, input logic [31:0] p,
                                              input int nregs, input int nmem);
      int j;
      j = k - H;
      if (j < 0)      return {16'hD0D0, 16'(1 + nregs + nmem)};
      if (j == 0)     return p;
      if (j <= nregs) return 32'h100 + 32'(j - 1);
      return 32'h200 + 32'(j - 1 - nregs);
   endfunction

   typedef struct {
      logic [31:0] pc;
      int          delay;
      int          abort_word;
      bit          noise;
      int          exp_strobes;
      int          exp_done;
   } row_t;

   row_t rows [NROWS];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, dbase, sbase, lat, n, tgt;
      bit seen, ok;

      rows[0] = '{32'hBFC0_0000, 10, -1,    1'b0, NW,    1};
      rows[1] = '{32'h0040_0010, 1,  -1,    1'b0, NW,    1};
      rows[2] = '{32'h1234_5678, 10, -1,    1'b1, NW,    1};
      rows[3] = '{32'hCAFE_0004, 6,  H + 3, 1'b0, H + 4, 0};
      rows[4] = '{32'h0000_0044, 3,  -1,    1'b0, NW,    1};
      rows[5] = '{32'h8000_0180, 1000, -1,  1'b0, NW,    1};
      for (int r = 6; r < NROWS; r++) begin
         rows[r].pc    = $urandom;
         rows[r].delay = int'($urandom_range(1, 12));
         if ($urandom_range(0, 2) == 0) begin
            rows[r].abort_word = int'($urandom_range(0, NW - 1));
            rows[r].noise      = 1'b0;
         end else begin
            rows[r].abort_word = -1;
            rows[r].noise      = 1'($urandom_range(0, 1));
         end
         rows[r].exp_strobes = (rows[r].abort_word < 0) ? NW : rows[r].abort_word + 1;
         rows[r].exp_done    = (rows[r].abort_word < 0) ? 1 : 0;
      end

      rst_n = 1'b0; main_start = 1'b0; abort = 1'b0; pc = '0;
      b_rst_n = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_done_in = 1'b0; b_pc = 32'h0040_0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_strobe", tx_start, 0);
      chk("reset_tx_data", tx_data, 0);
      chk("reset_reg_addr", reg_addr, 0);
      chk("reset_mem_addr", mem_addr, 0);
      @(posedge clk);
      #1 rst_n = 1'b1; b_rst_n = 1'b1;

      for (int r = 0; r < NROWS; r++) begin
         base  = got.size();
         dbase = done_cnt;
         sbase = stab_bad;
         pc = rows[r].pc; uart_delay = rows[r].delay; noise_on = rows[r].noise;
         @(posedge clk);
         #1 main_start = 1'b1;
         @(posedge clk);
         #1 main_start = 1'b0;
         lat = -1;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) chk($sformatf("row%0d_busy_on_start", r), busy, 1);
            if (tx_start) begin
               lat = c;
               break;
            end
         end
         chk($sformatf("row%0d_start_latency", r), lat, 2);

         if (rows[r].abort_word >= 0) begin
            @(posedge clk);
            for (int c = 0; c < 30000 && (got.size() - base) <= rows[r].abort_word; c++)
               @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
            @(negedge clk);
            chk($sformatf("row%0d_busy_after_abort", r), busy, 0);
            for (int c = 0; c < 30000 && uart_busy; c++) @(posedge clk);
            repeat (20) @(posedge clk);
         end else begin
            seen = 1'b0;
            for (int c = 0; c < 30000 && !seen; c++) begin
               @(negedge clk);
               seen = done;
            end
            repeat (3) @(negedge clk);
            chk($sformatf("row%0d_busy_after_done", r), busy, 0);
         end
         noise_on = 1'b0;
         repeat (2) @(negedge clk);

         n = got.size() - base;
         chk($sformatf("row%0d_strobes", r), n, rows[r].exp_strobes);
         chk($sformatf("row%0d_done_pulses", r), done_cnt - dbase, rows[r].exp_done);
         chk($sformatf("row%0d_hold_stable", r), stab_bad - sbase, 0);
         for (int k = 0; k < n && k < rows[r].exp_strobes; k++)
            chk($sformatf("row%0d_word%0d", r, k), got[base + k], model_word(k, rows[r].pc, SR, SM));
         $display("[TB] row %0d pc=%h delay=%0d abort=%0d noise=%0d strobes=%0d", r,
                  rows[r].pc, rows[r].delay, rows[r].abort_word, rows[r].noise, n);
      end

      // reset of the default-size instance while waiting on reg 5's transmit
      @(posedge clk);
      #1 b_start = 1'b1;
      @(posedge clk);
      #1 b_start = 1'b0;
      n = 0; tgt = H + 7; ok = 1'b1;
      while (ok && n < tgt) begin
         seen = 1'b0;
         for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            seen = b_tx_start;
         end
         if (!seen) begin
            ok = 1'b0;
         end else begin
            n++;
            if (n < tgt) begin
               @(posedge clk);
               #1 b_done_in = 1'b1;
               @(posedge clk);
               #1 b_done_in = 1'b0;
            end
         end
      end
      chk("big_strobes_to_reg5", n, tgt);
      chk("big_reg_addr_at_reg5", b_reg_addr, 5);
      chk("big_word_reg5", b_tx_data, 32'h105);
      @(posedge clk);
      #1 b_rst_n = 1'b0;
      @(posedge clk);
      #1 b_rst_n = 1'b1;
      @(negedge clk);
      chk("big_rst_busy", b_busy, 0);
      chk("big_rst_strobe", b_tx_start, 0);
      chk("big_rst_done", b_done, 0);
      chk("big_rst_tx_data", b_tx_data, 0);
      chk("big_rst_reg_addr", b_reg_addr, 0);
      chk("big_rst_mem_addr", b_mem_addr, 0);
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (b_tx_start || b_busy) seen = 1'b1;
      end
      chk("big_quiet_after_reset", seen, 0);
      $display("[TB] big reset at reg 5 strobes=%0d", n);

      @(posedge clk);
      #1 b_start = 1'b1;
      @(posedge clk);
      #1 b_start = 1'b0;
      lat = -1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (b_tx_start) begin
            lat = c;
            break;
         end
      end
      chk("big_restart_latency", lat, 2);
      chk("big_restart_first_word", b_tx_data, model_word(0, b_pc, BR, BM));
      @(posedge clk);
      #1 b_abort = 1'b1;
      @(posedge clk);
      #1 b_abort = 1'b0;
      @(negedge clk);
      chk("big_abort_busy", b_busy, 0);
      $display("[TB] big restart first word=%h", b_tx_data);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
